// File: rtl/uart_tx_cfg_if.sv
// Host handshake bundle for uart_tx_cfg: frame request with data/config in, ready/busy/done status out.
// The host drives the master side; the transmitter implements the slave side.
interface uart_tx_cfg_if #(
  parameter int DBIT = 8
);
  logic            tx_start;
  logic [DBIT-1:0] din;
  logic [1:0]      parity_mode;
  logic            stop2;
  logic            tx_ready;
  logic            tx_busy;
  logic            tx_done_tick;

  modport master (
    output tx_start, din, parity_mode, stop2,
    input  tx_ready, tx_busy, tx_done_tick
  );

  modport slave (
    input  tx_start, din, parity_mode, stop2,
    output tx_ready, tx_busy, tx_done_tick
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter (DBIT data, optional parity, 1/2 stop); start bit on the accepting edge.
// No queuing: tx_start is only honoured while tx_ready=1, otherwise dropped; frame lasts OVS*(1+DBIT+P+S) ticks.
module uart_tx_cfg #(
  parameter int DBIT = 8,
  parameter int OVS  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_tick,
  uart_tx_cfg_if.slave host,
  output logic        tx
);
  localparam int CW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int IW = $clog2(DBIT);
  localparam logic [CW-1:0] TICK_LAST = CW'(OVS - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   tick_q, tick_n;
  logic [IW-1:0]   idx_q, idx_n;
  logic [DBIT-1:0] shift_q, shift_n;
  logic [1:0]      mode_q, mode_n;
  logic            stop2_q, stop2_n;
  logic            par_q, par_n;
  logic            tx_q, tx_n;
  logic            done_q, done_n;
  logic            bit_end;
  logic            par_calc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      mode_q  <= '0;
      stop2_q <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      tick_q  <= tick_n;
      idx_q   <= idx_n;
      shift_q <= shift_n;
      mode_q  <= mode_n;
      stop2_q <= stop2_n;
      par_q   <= par_n;
      tx_q    <= tx_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    par_calc = 1'b0;
    case (host.parity_mode)
      2'b01:   par_calc = ^host.din;
      2'b10:   par_calc = ~^host.din;
      2'b11:   par_calc = 1'b1;
      default: par_calc = 1'b0;
    endcase
  end

  assign bit_end = s_tick && (tick_q == TICK_LAST);

  always_comb begin
    state_n = state_q;
    tick_n  = tick_q;
    idx_n   = idx_q;
    shift_n = shift_q;
    mode_n  = mode_q;
    stop2_n = stop2_q;
    par_n   = par_q;
    tx_n    = tx_q;
    done_n  = 1'b0;

    if (state_q == IDLE) begin
      tx_n = 1'b1;
      if (host.tx_start) begin
        shift_n = host.din;
        mode_n  = host.parity_mode;
        stop2_n = host.stop2;
        par_n   = par_calc;
        tick_n  = '0;
        idx_n   = '0;
        state_n = START;
        tx_n    = 1'b0;
      end
    end else if (s_tick) begin
      if (!bit_end) begin
        tick_n = tick_q + CW'(1);
      end else begin
        // Bit boundary: the next bit value is registered on this same edge.
        tick_n = '0;
        case (state_q)
          START: begin
            state_n = DATA;
            idx_n   = '0;
            tx_n    = shift_q[0];
          end
          DATA: begin
            if (idx_q == IDX_LAST) begin
              idx_n = '0;
              if (mode_q != 2'b00) begin
                state_n = PARITY;
                tx_n    = par_q;
              end else begin
                state_n = STOP;
                tx_n    = 1'b1;
              end
            end else begin
              idx_n   = idx_q + IW'(1);
              shift_n = shift_q >> 1;
              tx_n    = shift_q[1];
            end
          end
          PARITY: begin
            state_n = STOP;
            idx_n   = '0;
            tx_n    = 1'b1;
          end
          STOP: begin
            tx_n = 1'b1;
            // idx counts completed stop bits; two-stop frames run one extra period.
            if (idx_q == IW'(stop2_q)) begin
              state_n = IDLE;
              idx_n   = '0;
              done_n  = 1'b1;
            end else begin
              idx_n = idx_q + IW'(1);
            end
          end
          default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        endcase
      end
    end
  end

  assign tx                = tx_q;
  assign host.tx_ready     = (state_q == IDLE);
  assign host.tx_busy      = (state_q != IDLE);
  assign host.tx_done_tick = done_q;
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: vector table, corner-case sequences and random frames
// compared per clock against a bit-list model indexed by elapsed baud ticks.
module tb_uart_tx_cfg;
  localparam int DBIT = 8;
  localparam int OVS  = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic s_tick = 1'b0;
  logic tx;

  uart_tx_cfg_if #(.DBIT(DBIT)) bus ();

  uart_tx_cfg #(.DBIT(DBIT), .OVS(OVS)) dut (
    .clk    (clk),
    .reset  (reset),
    .s_tick (s_tick),
    .host   (bus.slave),
    .tx     (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int div = 1;
  int div_cnt = 0;
  bit edge_tick;
  bit exp_q[$];

  typedef struct {
    logic [7:0] din;
    logic [1:0] mode;
    logic       st2;
    int         exp_par;
    int         exp_len;
  } vec_t;

  vec_t vt[8];

  typedef struct {
    logic [7:0] din;
    logic [1:0] mode;
    logic       st2;
    int         dv;
    int         mid;
    bit         hold;
  } rnd_t;

  rnd_t rf[17];

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Drive s_tick for the coming edge, then step to the following negedge.
  task automatic adv();
    s_tick = (div_cnt == 0);
    edge_tick = s_tick;
    div_cnt = (div_cnt + 1) % div;
    @(negedge clk);
  endtask

  task automatic build(input logic [DBIT-1:0] d, input logic [1:0] m, input logic s2);
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < DBIT; i++) exp_q.push_back(d[i]);
    case (m)
      2'd1: exp_q.push_back(($countones(d) % 2) == 1);
      2'd2: exp_q.push_back(($countones(d) % 2) == 0);
      2'd3: exp_q.push_back(1'b1);
      default: ;
    endcase
    exp_q.push_back(1'b1);
    if (s2) exp_q.push_back(1'b1);
  endtask

  task automatic frame(input logic [DBIT-1:0] d, input logic [1:0] m, input logic s2,
                       input int mid, input bit hold,
                       input logic [DBIT-1:0] nd, input logic [1:0] nm, input logic nst,
                       output int len, output int par_seen);
    int n, ticks, bad, first_bad, dones, guard, limit;
    logic exp_tx, exp_done, exp_rdy;
    build(d, m, s2);
    n = exp_q.size();
    guard = 0;
    while (bus.tx_ready !== 1'b1 && guard < 20000) begin
      adv();
      guard++;
    end
    check("ready_before_start", bus.tx_ready, 1);
    bus.tx_start = 1'b1;
    bus.din = d;
    bus.parity_mode = m;
    bus.stop2 = s2;
    adv();
    ticks = 0; bad = 0; first_bad = -1; dones = 0; len = -1; par_seen = -1; guard = 0;
    limit = n * OVS * div * 2 + 50;
    forever begin
      if (ticks == n * OVS) begin
        exp_tx = 1'b1; exp_done = 1'b1; exp_rdy = 1'b1;
      end else begin
        exp_tx = exp_q[ticks / OVS]; exp_done = 1'b0; exp_rdy = 1'b0;
      end
      if (tx !== exp_tx || bus.tx_done_tick !== exp_done ||
          bus.tx_ready !== exp_rdy || bus.tx_busy !== !exp_rdy) begin
        if (bad == 0) first_bad = ticks;
        bad++;
      end
      if (bus.tx_done_tick === 1'b1) begin
        dones++;
        if (len < 0) len = ticks;
      end
      if (m != 2'd0 && ticks == (1 + DBIT) * OVS + OVS / 2) par_seen = int'(tx);
      if (ticks == n * OVS) break;
      if (hold) begin
        bus.tx_start = 1'b1; bus.din = nd; bus.parity_mode = nm; bus.stop2 = nst;
      end else begin
        // Config churn after accept must not leak into the running frame.
        bus.tx_start = (ticks == mid);
        bus.din = (ticks == mid) ? 8'hFF : 8'($urandom);
        bus.parity_mode = 2'($urandom);
        bus.stop2 = 1'($urandom);
      end
      adv();
      if (edge_tick) ticks++;
      guard++;
      if (guard > limit) begin
        check("frame_timeout", 1, 0);
        break;
      end
    end
    check($sformatf("wave_bad_cycles(first tick %0d, din %02h)", first_bad, d), bad, 0);
    check("done_pulses", dones, 1);
    if (!hold) bus.tx_start = 1'b0;
  endtask

  initial begin
    int len, par, guard, dones;
    bus.tx_start = 1'b0;
    bus.din = '0;
    bus.parity_mode = 2'd0;
    bus.stop2 = 1'b0;

    vt[0] = '{8'h55, 2'd0, 1'b0, -1, 160};
    vt[1] = '{8'h07, 2'd1, 1'b0,  1, 176};
    vt[2] = '{8'h07, 2'd2, 1'b0,  0, 176};
    vt[3] = '{8'h07, 2'd3, 1'b0,  1, 176};
    vt[4] = '{8'h07, 2'd1, 1'b1,  1, 192};
    vt[5] = '{8'h00, 2'd2, 1'b1,  1, 192};
    vt[6] = '{8'hFF, 2'd1, 1'b0,  0, 176};
    vt[7] = '{8'h80, 2'd3, 1'b1,  1, 192};

    #22;
    check("rst_tx", tx, 1);
    check("rst_ready", bus.tx_ready, 1);
    check("rst_busy", bus.tx_busy, 0);
    check("rst_done", bus.tx_done_tick, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) adv();
    check("idle_tx", tx, 1);

    foreach (vt[i]) begin
      frame(vt[i].din, vt[i].mode, vt[i].st2, -1, 1'b0, '0, '0, 1'b0, len, par);
      check($sformatf("vec%0d_len", i), len, vt[i].exp_len);
      if (vt[i].exp_par >= 0) check($sformatf("vec%0d_parity", i), par, vt[i].exp_par);
      adv();
      check($sformatf("vec%0d_done_one_clk", i), bus.tx_done_tick, 0);
    end

    // tx_start with 0xFF in the middle of DATA is dropped.
    frame(8'h55, 2'd0, 1'b0, OVS * 3 + 4, 1'b0, '0, '0, 1'b0, len, par);
    check("busy_start_len", len, 160);

    // Request held across done: second start bit follows immediately.
    frame(8'hA5, 2'd1, 1'b1, -1, 1'b1, 8'h3C, 2'd2, 1'b0, len, par);
    check("b2b_first_len", len, 192);
    frame(8'h3C, 2'd2, 1'b0, -1, 1'b0, '0, '0, 1'b0, len, par);
    check("b2b_second_len", len, 176);
    check("b2b_second_parity", par, 1);

    // Async reset during DATA bit 3 aborts without a done pulse.
    bus.tx_start = 1'b1; bus.din = 8'h3C; bus.parity_mode = 2'd1; bus.stop2 = 1'b0;
    div_cnt = 0;
    adv();
    bus.tx_start = 1'b0;
    repeat (OVS * 4 + 5) adv();
    #2 reset = 1'b0;
    #1;
    check("abort_tx", tx, 1);
    check("abort_ready", bus.tx_ready, 1);
    check("abort_busy", bus.tx_busy, 0);
    check("abort_done", bus.tx_done_tick, 0);
    @(negedge clk);
    reset = 1'b1;
    dones = 0;
    for (guard = 0; guard < 200; guard++) begin
      adv();
      if (bus.tx_done_tick === 1'b1 || tx !== 1'b1) dones++;
    end
    check("abort_quiet_cycles", dones, 0);
    frame(8'h55, 2'd0, 1'b0, -1, 1'b0, '0, '0, 1'b0, len, par);
    check("after_abort_len", len, 160);

    // Sparse ticks: line stretches, same bit pattern.
    div = 4;
    div_cnt = 0;
    frame(8'h55, 2'd0, 1'b0, -1, 1'b0, '0, '0, 1'b0, len, par);
    check("div4_len", len, 160);

    foreach (rf[i]) begin
      rf[i].din  = 8'($urandom);
      rf[i].mode = 2'($urandom);
      rf[i].st2  = 1'($urandom);
      rf[i].dv   = $urandom_range(1, 3);
      rf[i].mid  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 150) : -1;
      rf[i].hold = ($urandom_range(0, 3) == 0);
    end
    rf[16].hold = 1'b0;
    for (int i = 0; i < 17; i++) begin
      div = rf[i].dv;
      div_cnt = 0;
      frame(rf[i].din, rf[i].mode, rf[i].st2, rf[i].mid, (i < 16) ? rf[i].hold : 1'b0,
            (i < 16) ? rf[i + 1].din : 8'h00, (i < 16) ? rf[i + 1].mode : 2'd0,
            (i < 16) ? rf[i + 1].st2 : 1'b0, len, par);
      check($sformatf("rnd%0d_len", i), len,
            OVS * (1 + DBIT + ((rf[i].mode != 2'd0) ? 1 : 0) + (rf[i].st2 ? 2 : 1)));
    end
    adv();
    check("final_done_clear", bus.tx_done_tick, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
